// File: rtl/io_cfg_pkg.sv
// Shared types and constants for the IO tile ccff configuration loader.
// Holds the loader state encoding and the CRC-8 parameters used by both checkers.
package io_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISOLATE = 3'd1,
        ST_LOAD    = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_RELEASE = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One serial CRC-8 step, MSB-first register update.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Serial CRC-8 accumulator: one bit per enabled clock, synchronous clear.
module crc8_serial
    import io_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (clr) begin
            crc <= CRC8_INIT;
        end else if (en) begin
            crc <= crc8_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/io_ccff_loader.sv
// Loads an IO tile ccff chain from a word stream under pad isolation, then
// recirculates the chain once and compares CRCs before releasing the pads.
module io_ccff_loader
    import io_cfg_pkg::*;
#(
    parameter int CHAIN_LEN   = 64,
    parameter int WORD_W      = 8,
    parameter int ISOL_CYCLES = 4
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              cfg_shift_en,
    output logic              io_isol_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int HW = $clog2(WORD_W + 1);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        iso_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [WORD_W-1:0] hold_data;
    logic [HW-1:0]     hold_cnt;
    logic              released;

    logic              hold_empty;
    logic              take;
    logic              shift_bit;
    logic              load_shift;
    logic              verify_shift;
    logic              last_load_bit;
    logic              crc_clr;
    logic [7:0]        load_crc;
    logic [7:0]        chk_crc;

    // An empty holding register passes word_data[0] straight to the chain in the
    // accept cycle, so consecutive words shift with no bubble.
    always_comb begin
        hold_empty    = (hold_cnt == '0);
        word_ready    = (state == ST_LOAD) && hold_empty;
        take          = word_ready && word_valid;
        shift_bit     = hold_empty ? word_data[0] : hold_data[0];
        load_shift    = (state == ST_LOAD) && (take || !hold_empty);
        verify_shift  = (state == ST_VERIFY) && (bit_cnt != BW'(CHAIN_LEN));
        last_load_bit = load_shift && (bit_cnt == BW'(CHAIN_LEN - 1));
        cfg_shift_en  = load_shift || verify_shift;
        ccff_head     = 1'b0;
        if (load_shift) begin
            ccff_head = shift_bit;
        end else if (verify_shift) begin
            ccff_head = ccff_tail;
        end
        busy      = (state != ST_IDLE);
        done      = (state == ST_RELEASE);
        error     = (state == ST_FAIL);
        io_isol_n = done || ((state == ST_IDLE) && released);
        crc_clr   = !pReset || (state == ST_IDLE);
    end

    // VERIFY ends with one non-shifting cycle so the registered chk_crc already
    // includes the final recirculated bit when it is compared.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start && !abort) state_nx = ST_ISOLATE;
            end
            ST_ISOLATE: begin
                if (abort)                                  state_nx = ST_FAIL;
                else if (iso_cnt == 8'(ISOL_CYCLES - 1))    state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                if (abort)              state_nx = ST_FAIL;
                else if (last_load_bit) state_nx = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (abort)              state_nx = ST_FAIL;
                else if (!verify_shift) state_nx = (chk_crc == load_crc) ? ST_RELEASE : ST_FAIL;
            end
            ST_RELEASE: state_nx = ST_IDLE;
            ST_FAIL:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state     <= ST_IDLE;
            iso_cnt   <= '0;
            bit_cnt   <= '0;
            hold_data <= '0;
            hold_cnt  <= '0;
            released  <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == ST_ISOLATE) iso_cnt <= iso_cnt + 8'd1;
            else                     iso_cnt <= '0;

            if (state_nx != state)   bit_cnt <= '0;
            else if (cfg_shift_en)   bit_cnt <= bit_cnt + 1'b1;

            if ((state != ST_LOAD) || (state_nx != ST_LOAD)) begin
                hold_data <= '0;
                hold_cnt  <= '0;
            end else if (take) begin
                hold_data <= word_data >> 1;
                hold_cnt  <= HW'(WORD_W - 1);
            end else if (!hold_empty) begin
                hold_data <= hold_data >> 1;
                hold_cnt  <= hold_cnt - 1'b1;
            end

            if (state == ST_RELEASE)        released <= 1'b1;
            else if (state_nx == ST_ISOLATE) released <= 1'b0;
        end
    end

    crc8_serial u_load_crc (
        .clk    (prog_clk),
        .clr    (crc_clr),
        .en     (load_shift),
        .bit_in (shift_bit),
        .crc    (load_crc)
    );

    crc8_serial u_chk_crc (
        .clk    (prog_clk),
        .clr    (crc_clr),
        .en     (verify_shift),
        .bit_in (ccff_tail),
        .crc    (chk_crc)
    );

endmodule

// File: tb/tb_io_ccff_loader.sv
// Self-checking bench for io_ccff_loader: two instances (16- and 12-bit chains)
// with behavioural chain models and a stream-level reference for expectations.
module tb_io_ccff_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       abort;
    logic       wvalid;
    logic [7:0] wdata;
    logic       flip;
    int         sel;

    logic rdy_a, head_a, sh_a, isol_a, busy_a, done_a, err_a;
    logic rdy_b, head_b, sh_b, isol_b, busy_b, done_b, err_b;
    logic [15:0] chain_a;
    logic [11:0] chain_b;

    io_ccff_loader #(.CHAIN_LEN(16), .WORD_W(8), .ISOL_CYCLES(4)) u_a (
        .prog_clk(clk), .pReset(rst_n), .start(start && sel == 0), .abort(abort && sel == 0),
        .word_valid(wvalid && sel == 0), .word_data(wdata), .word_ready(rdy_a),
        .ccff_head(head_a), .ccff_tail(chain_a[0]), .cfg_shift_en(sh_a),
        .io_isol_n(isol_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    io_ccff_loader #(.CHAIN_LEN(12), .WORD_W(8), .ISOL_CYCLES(3)) u_b (
        .prog_clk(clk), .pReset(rst_n), .start(start && sel == 1), .abort(abort && sel == 1),
        .word_valid(wvalid && sel == 1), .word_data(wdata), .word_ready(rdy_b),
        .ccff_head(head_b), .ccff_tail(chain_b[0]), .cfg_shift_en(sh_b),
        .io_isol_n(isol_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    // Chain models: a plain shift register per instance, optional single-bit upset.
    always @(posedge clk) begin : model_a
        logic [15:0] nx;
        nx = chain_a;
        if (sh_a) nx = {head_a, chain_a[15:1]};
        if (flip && sel == 0) nx[6] = ~nx[6];
        chain_a <= nx;
    end

    always @(posedge clk) begin : model_b
        logic [11:0] nx;
        nx = chain_b;
        if (sh_b) nx = {head_b, chain_b[11:1]};
        if (flip && sel == 1) nx[6] = ~nx[6];
        chain_b <= nx;
    end

    logic rdy, head, sh, isol, busy, done, err, tail;
    logic [15:0] chain_m;
    assign rdy     = (sel == 0) ? rdy_a  : rdy_b;
    assign head    = (sel == 0) ? head_a : head_b;
    assign sh      = (sel == 0) ? sh_a   : sh_b;
    assign isol    = (sel == 0) ? isol_a : isol_b;
    assign busy    = (sel == 0) ? busy_a : busy_b;
    assign done    = (sel == 0) ? done_a : done_b;
    assign err     = (sel == 0) ? err_a  : err_b;
    assign tail    = (sel == 0) ? chain_a[0] : chain_b[0];
    assign chain_m = (sel == 0) ? chain_a : {4'b0, chain_b};

    int total = 0;
    int bad   = 0;

    logic [7:0] wq[$];
    int         gq[$];

    int r_iso, r_lshift, r_vshift, r_stalls, r_ready_after, r_accepted;
    int r_done, r_err, r_post_abort, r_abort_lat, r_head_err, r_rst_bad;
    logic r_isol_pulse, r_isol_after, r_busy_after, r_rst_seen;
    logic [15:0] r_chain;

    function automatic int chain_len(input int s);
        return (s == 0) ? 16 : 12;
    endfunction

    function automatic int isol_len(input int s);
        return (s == 0) ? 4 : 3;
    endfunction

    // Bit i of the concatenated stream, words consumed LSB first.
    function automatic logic sbit(input int i);
        logic [7:0] w;
        w = wq[i / 8];
        return w[i % 8];
    endfunction

    // After n shifts the first stream bit sits at the tail end (bit 0).
    function automatic logic [15:0] exp_chain(input int n);
        logic [15:0] e;
        e = '0;
        for (int i = 0; i < n; i++) e[i] = sbit(i);
        return e;
    endfunction

    task automatic run_load(input int s, input int abort_at, input int flip_at,
                            input int rst_at, input bit noise);
        int  n, k, kb, widx, gap_left, abort_cyc;
        bit  aborted, flipped, fin;
        n = chain_len(s);
        sel = s;
        r_iso = 0; r_lshift = 0; r_vshift = 0; r_stalls = 0; r_ready_after = 0;
        r_accepted = 0; r_done = 0; r_err = 0; r_post_abort = 0; r_abort_lat = -1;
        r_head_err = 0; r_rst_bad = 0; r_rst_seen = 1'b0; r_isol_pulse = 1'b0;
        k = 0; widx = 0; abort_cyc = -1; aborted = 1'b0; flipped = 1'b0; fin = 1'b0;
        gap_left = (gq.size() > 0) ? gq[0] : 0;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; wvalid = 1'b0; flip = 1'b0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(negedge clk);
            kb     = k;
            start  = noise && ($urandom_range(0, 3) == 0);
            wvalid = (widx < wq.size()) && (gap_left == 0);
            wdata  = wvalid ? wq[widx] : 8'($urandom);
            abort  = (abort_at >= 0) && !aborted && (k == abort_at);
            flip   = (flip_at >= 0) && !flipped && (k == n + flip_at);
            rst_n  = !((rst_at >= 0) && (k == n + rst_at));
            if (flip) flipped = 1'b1;
            #1;
            if (abort) begin
                aborted = 1'b1;
                abort_cyc = cyc;
            end else if (aborted && sh) begin
                r_post_abort++;
            end
            if (busy && k == 0 && !sh) r_iso++;
            if (sh) begin
                if (k < n) begin
                    r_lshift++;
                    if (head !== sbit(k)) r_head_err++;
                end else begin
                    r_vshift++;
                    if (head !== tail) r_head_err++;
                end
                k++;
            end else if (busy && k > 0 && k < n) begin
                r_stalls++;
            end
            if (rdy && kb >= n) r_ready_after++;
            if (wvalid && rdy) begin
                r_accepted++;
                widx++;
                gap_left = (widx < gq.size()) ? gq[widx] : 0;
            end else if (rdy && gap_left > 0) begin
                gap_left--;
            end
            if (done) r_done++;
            if (err) begin
                r_err++;
                if (abort_cyc >= 0) r_abort_lat = cyc - abort_cyc;
            end
            if (done || err) begin
                r_isol_pulse = isol;
                fin = 1'b1;
            end
            if (!rst_n) begin
                @(negedge clk);
                rst_n = 1'b1; start = 1'b0; abort = 1'b0; wvalid = 1'b0; flip = 1'b0;
                #1;
                if ({rdy, head, sh, isol, busy, done, err} !== 7'b0) r_rst_bad++;
                r_rst_seen = 1'b1;
                fin = 1'b1;
            end
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL run_timeout sel=%0d got=no done/error/reset required=termination within 600 cycles", s);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; wvalid = 1'b0; flip = 1'b0;
        #1;
        if (aborted && sh) r_post_abort++;
        r_busy_after = busy;
        r_isol_after = isol;
        r_chain      = chain_m;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; wvalid = 1'b0; wdata = '0; flip = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({rdy_a, head_a, sh_a, isol_a, busy_a, done_a, err_a} !== 7'b0) begin
            bad++;
            $display("FAIL reset_a got=%b required=0000000", {rdy_a, head_a, sh_a, isol_a, busy_a, done_a, err_a});
        end
        total++;
        if ({rdy_b, head_b, sh_b, isol_b, busy_b, done_b, err_b} !== 7'b0) begin
            bad++;
            $display("FAIL reset_b got=%b required=0000000", {rdy_b, head_b, sh_b, isol_b, busy_b, done_b, err_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_abort_with_start();
        int busy_seen;
        busy_seen = 0;
        sel = 0;
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        total++;
        if (busy_seen !== 0) begin
            bad++;
            $display("FAIL abort_with_start busy_cycles got=%0d required=0", busy_seen);
        end
    endtask

    task automatic test_back_to_back();
        wq = '{8'hA5, 8'h3C};
        gq = '{0, 0};
        run_load(0, -1, -1, -1, 1'b0);
        total++; if (r_iso !== 4) begin bad++; $display("FAIL b2b_isolate got=%0d required=4", r_iso); end
        total++; if (r_lshift !== 16) begin bad++; $display("FAIL b2b_load_shifts got=%0d required=16", r_lshift); end
        total++; if (r_stalls !== 0) begin bad++; $display("FAIL b2b_stalls got=%0d required=0", r_stalls); end
        total++; if (r_vshift !== 16) begin bad++; $display("FAIL b2b_verify_shifts got=%0d required=16", r_vshift); end
        total++; if (r_head_err !== 0) begin bad++; $display("FAIL b2b_head_bits got=%0d wrong required=0", r_head_err); end
        total++; if (r_chain !== 16'h3CA5) begin bad++; $display("FAIL b2b_chain got=%h required=3ca5", r_chain); end
        total++; if (r_done !== 1 || r_err !== 0) begin bad++; $display("FAIL b2b_status got=done%0d/err%0d required=done1/err0", r_done, r_err); end
        total++; if (r_isol_pulse !== 1'b1 || r_isol_after !== 1'b1) begin bad++; $display("FAIL b2b_isol got=%b%b required=11", r_isol_pulse, r_isol_after); end
        total++; if (r_busy_after !== 1'b0) begin bad++; $display("FAIL b2b_busy_after got=%b required=0", r_busy_after); end
    endtask

    task automatic test_gap();
        wq = '{8'hA5, 8'h3C};
        gq = '{0, 3};
        run_load(0, -1, -1, -1, 1'b0);
        total++; if (r_stalls !== 3) begin bad++; $display("FAIL gap_stalls got=%0d required=3", r_stalls); end
        total++; if (r_lshift !== 16) begin bad++; $display("FAIL gap_load_shifts got=%0d required=16", r_lshift); end
        total++; if (r_chain !== 16'h3CA5) begin bad++; $display("FAIL gap_chain got=%h required=3ca5", r_chain); end
        total++; if (r_done !== 1 || r_err !== 0) begin bad++; $display("FAIL gap_status got=done%0d/err%0d required=done1/err0", r_done, r_err); end
    endtask

    task automatic test_truncate();
        wq = '{8'hFF, 8'h0F, 8'h55};
        gq = '{0, 0, 0};
        run_load(1, -1, -1, -1, 1'b0);
        total++; if (r_iso !== 3) begin bad++; $display("FAIL trunc_isolate got=%0d required=3", r_iso); end
        total++; if (r_lshift !== 12) begin bad++; $display("FAIL trunc_load_shifts got=%0d required=12", r_lshift); end
        total++; if (r_accepted !== 2) begin bad++; $display("FAIL trunc_accepted got=%0d required=2", r_accepted); end
        total++; if (r_ready_after !== 0) begin bad++; $display("FAIL trunc_ready_after got=%0d required=0", r_ready_after); end
        total++; if (r_chain !== 16'h0FFF) begin bad++; $display("FAIL trunc_chain got=%h required=0fff", r_chain); end
        total++; if (r_done !== 1 || r_head_err !== 0) begin bad++; $display("FAIL trunc_status got=done%0d/headerr%0d required=done1/headerr0", r_done, r_head_err); end
    endtask

    task automatic test_verify_fault();
        wq = '{8'h5A, 8'hC3};
        gq = '{0, 0};
        run_load(0, -1, 5, -1, 1'b0);
        total++; if (r_err !== 1 || r_done !== 0) begin bad++; $display("FAIL vfault_status got=done%0d/err%0d required=done0/err1", r_done, r_err); end
        total++; if (r_isol_pulse !== 1'b0 || r_isol_after !== 1'b0) begin bad++; $display("FAIL vfault_isol got=%b%b required=00", r_isol_pulse, r_isol_after); end
    endtask

    task automatic test_abort_load();
        wq = '{8'hA5, 8'h3C};
        gq = '{0, 0};
        run_load(0, 5, -1, -1, 1'b0);
        total++; if (r_abort_lat !== 1) begin bad++; $display("FAIL abort_latency got=%0d required=1", r_abort_lat); end
        total++; if (r_err !== 1 || r_done !== 0) begin bad++; $display("FAIL abort_status got=done%0d/err%0d required=done0/err1", r_done, r_err); end
        total++; if (r_post_abort !== 0) begin bad++; $display("FAIL abort_post_shifts got=%0d required=0", r_post_abort); end
        total++; if (r_lshift < 5 || r_lshift > 6) begin bad++; $display("FAIL abort_load_shifts got=%0d required=5..6", r_lshift); end
        total++; if (r_isol_after !== 1'b0) begin bad++; $display("FAIL abort_isol got=%b required=0", r_isol_after); end
    endtask

    task automatic test_reset_mid_verify();
        wq = '{8'h96, 8'h71};
        gq = '{0, 0};
        run_load(0, -1, -1, 4, 1'b0);
        total++; if (r_rst_seen !== 1'b1 || r_rst_bad !== 0) begin bad++; $display("FAIL rstmid_outputs got=seen%b/bad%0d required=seen1/bad0", r_rst_seen, r_rst_bad); end
        total++; if (r_done !== 0 || r_busy_after !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=done%0d/busy%b required=done0/busy0", r_done, r_busy_after); end
        wq = '{8'h2B, 8'hE4};
        run_load(0, -1, -1, -1, 1'b0);
        total++; if (r_iso !== 4 || r_lshift !== 16) begin bad++; $display("FAIL rstmid_reload got=iso%0d/shifts%0d required=iso4/shifts16", r_iso, r_lshift); end
        total++; if (r_chain !== 16'hE42B) begin bad++; $display("FAIL rstmid_chain got=%h required=e42b", r_chain); end
        total++; if (r_done !== 1 || r_err !== 0) begin bad++; $display("FAIL rstmid_status got=done%0d/err%0d required=done1/err0", r_done, r_err); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int s, n, need, sumg;
            s = int'($urandom_range(0, 1));
            n = chain_len(s);
            need = (n + 7) / 8;
            sumg = 0;
            wq.delete();
            gq.delete();
            for (int j = 0; j < need + 1; j++) begin
                wq.push_back(8'($urandom));
                gq.push_back(int'($urandom_range(0, 3)));
                if (j >= 1 && j < need) sumg += gq[j];
            end
            run_load(s, -1, -1, -1, 1'b1);
            total++; if (r_iso !== isol_len(s) + gq[0]) begin bad++; $display("FAIL rnd%0d_isolate got=%0d required=%0d", it, r_iso, isol_len(s) + gq[0]); end
            total++; if (r_lshift !== n || r_vshift !== n) begin bad++; $display("FAIL rnd%0d_shifts got=%0d/%0d required=%0d/%0d", it, r_lshift, r_vshift, n, n); end
            total++; if (r_stalls !== sumg) begin bad++; $display("FAIL rnd%0d_stalls got=%0d required=%0d", it, r_stalls, sumg); end
            total++; if (r_accepted !== need) begin bad++; $display("FAIL rnd%0d_accepted got=%0d required=%0d", it, r_accepted, need); end
            total++; if (r_head_err !== 0) begin bad++; $display("FAIL rnd%0d_head_bits got=%0d wrong required=0", it, r_head_err); end
            total++; if (r_chain !== exp_chain(n)) begin bad++; $display("FAIL rnd%0d_chain got=%h required=%h", it, r_chain, exp_chain(n)); end
            total++; if (r_done !== 1 || r_err !== 0 || r_isol_after !== 1'b1) begin bad++; $display("FAIL rnd%0d_status got=done%0d/err%0d/isol%b required=done1/err0/isol1", it, r_done, r_err, r_isol_after); end
        end
    endtask

    initial begin
        test_reset();
        test_abort_with_start();
        test_back_to_back();
        test_gap();
        test_truncate();
        test_verify_fault();
        test_abort_load();
        test_reset_mid_verify();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
